// File: rtl/processor_amplitud_pkg.sv
// ----------------------------------------------------------------------------
// processor_amplitud_pkg
// Shared definitions for the amplitude arbiter: FSM state encoding, the
// default frame header tag, and the header word layout.
// ----------------------------------------------------------------------------
package processor_amplitud_pkg;

    localparam int          FRAME_CNT_W     = 8;
    localparam int          HDR_W           = 32;
    localparam logic [15:0] HDR_TAG_DEFAULT = 16'hA5A5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Header word: {tag[15:0], frame_count[7:0], channel_count[7:0]}
    function automatic logic [HDR_W-1:0] make_header(
        input logic [15:0]            tag,
        input logic [FRAME_CNT_W-1:0] count,
        input logic [7:0]             num_ch
    );
        return {tag, count, num_ch};
    endfunction

endpackage

// File: rtl/processor_amplitud_arbiter_if.sv
// ----------------------------------------------------------------------------
// processor_amplitud_arbiter_if
// Bundles the requester side (per-channel amplitude words and strobes, mode
// and status controls) with the source side (FIFO write port, overrun flags,
// frame counter).
//   master : drives ch_data, ch_valid, frame_mode, fifo_almost_full,
//            clear_status; observes the source/status outputs.
//   slave  : the arbiter; the reverse directions.
// ----------------------------------------------------------------------------
interface processor_amplitud_arbiter_if
    import processor_amplitud_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic                     frame_mode;
    logic                     fifo_almost_full;
    logic                     clear_status;
    logic [DATA_W-1:0]        avalonst_source_data;
    logic                     avalonst_source_valid;
    logic [NUM_CH-1:0]        overrun;
    logic [FRAME_CNT_W-1:0]   frame_count;

    modport master (
        output ch_data, ch_valid, frame_mode, fifo_almost_full, clear_status,
        input  avalonst_source_data, avalonst_source_valid, overrun, frame_count
    );

    modport slave (
        input  ch_data, ch_valid, frame_mode, fifo_almost_full, clear_status,
        output avalonst_source_data, avalonst_source_valid, overrun, frame_count
    );
endinterface

// File: rtl/processor_amplitud_rr_select.sv
// ----------------------------------------------------------------------------
// processor_amplitud_rr_select
// Combinational round-robin picker. Searches the pending mask starting at
// start_ptr (wrapping) and returns the first pending channel.
//   pending   : channels with a held word
//   start_ptr : highest-priority channel this cycle (one past last issued)
//   grant     : one-hot grant
//   grant_idx : index of the granted channel
//   any       : a grant was made
// ----------------------------------------------------------------------------
module processor_amplitud_rr_select #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [IDX_W-1:0]  start_ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);
    // One spare bit so start_ptr + offset cannot overflow before the wrap.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, start_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_CH)) begin
                sum = sum - (IDX_W+1)'(NUM_CH);
            end
            idx = sum[IDX_W-1:0];
            if (!any && pending[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/processor_amplitud_arbiter.sv
// ----------------------------------------------------------------------------
// processor_amplitud_arbiter
// Collects one amplitude word per channel into holding registers and issues
// them to a downstream FIFO, either round-robin as they arrive (stream mode)
// or as a header-prefixed frame once every channel holds a word (frame mode).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : ch_data/ch_valid in, frame_mode, fifo_almost_full,
//                  clear_status in; avalonst_source_data/valid, overrun,
//                  frame_count out
// ----------------------------------------------------------------------------
module processor_amplitud_arbiter
    import processor_amplitud_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          DATA_W  = 32,
    parameter logic [15:0] HDR_TAG = HDR_TAG_DEFAULT
) (
    input logic                         clock,
    input logic                         reset,
    processor_amplitud_arbiter_if.slave bus
);
    localparam int               IDX_W       = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_CH     = IDX_W'(NUM_CH - 1);
    localparam logic [7:0]       NUM_CH_BYTE = 8'(NUM_CH);

    state_e                 state_q, state_nx;
    logic [NUM_CH-1:0]      pending_q, pending_nx;
    logic [NUM_CH-1:0]      overrun_q, ov_set;
    logic [NUM_CH-1:0]      issue_oh;
    logic [DATA_W-1:0]      hold_q [NUM_CH];
    logic [IDX_W-1:0]       ptr_q, ptr_nx;
    logic [IDX_W-1:0]       cnt_q, cnt_nx;
    logic [FRAME_CNT_W-1:0] fc_q, fc_nx;
    logic                   issue_valid;
    logic [DATA_W-1:0]      issue_word;
    logic                   src_valid_q;
    logic [DATA_W-1:0]      src_data_q;

    logic [NUM_CH-1:0]      rr_grant;
    logic [IDX_W-1:0]       rr_idx;
    logic                   rr_any;

    processor_amplitud_rr_select #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_select (
        .pending   (pending_q),
        .start_ptr (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // A strobe always (re)sets pending; issuing clears it only when no new
    // word lands on the same edge. Overrun marks a word lost to overwrite,
    // which cannot happen when the old word is leaving this very cycle.
    assign pending_nx = (pending_q & ~issue_oh) | bus.ch_valid;
    assign ov_set     = bus.ch_valid & pending_q & ~issue_oh;

    always_comb begin
        state_nx    = state_q;
        ptr_nx      = ptr_q;
        cnt_nx      = cnt_q;
        fc_nx       = fc_q;
        issue_oh    = '0;
        issue_valid = 1'b0;
        issue_word  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.frame_mode) begin
                    if (&pending_q) begin
                        state_nx = ST_HDR;
                    end
                end else if (!bus.fifo_almost_full && rr_any) begin
                    issue_oh    = rr_grant;
                    issue_valid = 1'b1;
                    issue_word  = hold_q[rr_idx];
                    ptr_nx      = (rr_idx == LAST_CH) ? '0 : rr_idx + 1'b1;
                end
            end
            ST_HDR: begin
                if (!bus.fifo_almost_full) begin
                    issue_valid = 1'b1;
                    issue_word  = DATA_W'(make_header(HDR_TAG, fc_q, NUM_CH_BYTE));
                    cnt_nx      = '0;
                    state_nx    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!bus.fifo_almost_full) begin
                    issue_oh[cnt_q] = 1'b1;
                    issue_valid     = 1'b1;
                    issue_word      = hold_q[cnt_q];
                    if (cnt_q == LAST_CH) begin
                        cnt_nx   = '0;
                        fc_nx    = fc_q + 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            overrun_q   <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            fc_q        <= '0;
            src_valid_q <= 1'b0;
            src_data_q  <= '0;
        end else begin
            state_q     <= state_nx;
            pending_q   <= pending_nx;
            overrun_q   <= ov_set | (bus.clear_status ? '0 : overrun_q);
            ptr_q       <= ptr_nx;
            cnt_q       <= cnt_nx;
            fc_q        <= fc_nx;
            src_valid_q <= issue_valid;
            if (issue_valid) begin
                src_data_q <= issue_word;
            end
        end
    end

    // NOTE: holding registers carry no reset; a word is only ever read while
    // its pending bit is set, and pending bits are reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_valid[i]) begin
                hold_q[i] <= bus.ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.avalonst_source_valid = src_valid_q;
    assign bus.avalonst_source_data  = src_data_q;
    assign bus.overrun               = overrun_q;
    assign bus.frame_count           = fc_q;
endmodule

// File: tb/tb_processor_amplitud_arbiter.sv
// ----------------------------------------------------------------------------
// tb_processor_amplitud_arbiter
// Directed bench for processor_amplitud_arbiter (NUM_CH=4, DATA_W=32).
// Inputs are driven 1 ns after the rising edge; the word monitor samples on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_processor_amplitud_arbiter;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    processor_amplitud_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    processor_amplitud_arbiter #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .HDR_TAG (16'hA5A5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] words[$];

    always @(negedge clock) begin
        if (bus.avalonst_source_valid) words.push_back(bus.avalonst_source_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_ch(input int ch, input logic [31:0] w);
        bus.ch_data[ch*DATA_W +: DATA_W] = w;
    endtask

    // Strobe all channels with base, base+1, ... for one cycle.
    task automatic strobe_all(input logic [31:0] base);
        for (int i = 0; i < NUM_CH; i++) set_ch(i, base + 32'(i));
        bus.ch_valid = '1;
        step();
        bus.ch_valid = '0;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        for (int c = 0; c < budget && words.size() < n; c++) @(negedge clock);
        #1;
        check(tag, 32'(words.size()), 32'(n));
    endtask

    task automatic check_frame(input string tag, input logic [31:0] hdr, input logic [31:0] base);
        if (words.size() >= 5) begin
            check({tag, " hdr"}, words[0], hdr);
            for (int i = 0; i < NUM_CH; i++) check({tag, " data"}, words[i+1], base + 32'(i));
        end
    endtask

    int          frames;
    logic [7:0]  prev_fc;

    initial begin
        reset                = 1'b1;
        bus.ch_data          = '0;
        bus.ch_valid         = '0;
        bus.frame_mode       = 1'b0;
        bus.fifo_almost_full = 1'b0;
        bus.clear_status     = 1'b0;
        step(2);
        check("reset valid", 32'(bus.avalonst_source_valid), 32'd0);
        check("reset data", bus.avalonst_source_data, 32'd0);
        check("reset overrun", 32'(bus.overrun), 32'd0);
        check("reset frame_count", 32'(bus.frame_count), 32'd0);
        reset = 1'b0;
        step();

        // Stream mode: four words in one cycle, issued ch0..ch3 back to back.
        strobe_all(32'h10);
        check("stream latency", 32'(bus.avalonst_source_valid), 32'd0);
        for (int k = 0; k < NUM_CH; k++) begin
            step();
            check("stream valid", 32'(bus.avalonst_source_valid), 32'd1);
            check("stream data", bus.avalonst_source_data, 32'h10 + 32'(k));
        end
        step();
        check("stream drained", 32'(bus.avalonst_source_valid), 32'd0);

        // Frame mode: staggered strobes, then header + four words.
        bus.frame_mode = 1'b1;
        words.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            set_ch(i, 32'hA + 32'(i));
            bus.ch_valid = 4'(1 << i);
            step();
        end
        bus.ch_valid = '0;
        wait_words(5, 20, "frame0 count");
        step(3);
        check("frame0 no extra", 32'(words.size()), 32'd5);
        check_frame("frame0", 32'hA5A5_0004, 32'hA);
        check("frame0 frame_count", 32'(bus.frame_count), 32'd1);

        // Five-cycle FIFO stall after header and ch0.
        words.delete();
        strobe_all(32'h20);
        step(3);
        bus.fifo_almost_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall valid", 32'(bus.avalonst_source_valid), 32'd0);
        end
        bus.fifo_almost_full = 1'b0;
        wait_words(5, 20, "stall count");
        step(3);
        check("stall no extra", 32'(words.size()), 32'd5);
        check_frame("stall", 32'hA5A5_0104, 32'h20);
        check("stall frame_count", 32'(bus.frame_count), 32'd2);

        // Overwrite of ch2 while the FIFO is full.
        bus.frame_mode       = 1'b0;
        bus.fifo_almost_full = 1'b1;
        set_ch(2, 32'h1);
        bus.ch_valid = 4'b0100;
        step();
        set_ch(2, 32'h2);
        step();
        bus.ch_valid = '0;
        check("overrun set", 32'(bus.overrun), 32'h4);
        check("full no valid", 32'(bus.avalonst_source_valid), 32'd0);
        bus.fifo_almost_full = 1'b0;
        step();
        check("overrun word valid", 32'(bus.avalonst_source_valid), 32'd1);
        check("overrun word data", bus.avalonst_source_data, 32'h2);
        step();
        check("overrun single word", 32'(bus.avalonst_source_valid), 32'd0);
        bus.clear_status = 1'b1;
        step();
        bus.clear_status = 1'b0;
        check("overrun cleared", 32'(bus.overrun), 32'd0);

        // Strobe landing in the cycle its channel is issued.
        set_ch(1, 32'h5);
        bus.ch_valid = 4'b0010;
        step();
        set_ch(1, 32'h6);
        step();
        bus.ch_valid = '0;
        check("same-cycle old valid", 32'(bus.avalonst_source_valid), 32'd1);
        check("same-cycle old data", bus.avalonst_source_data, 32'h5);
        step();
        check("same-cycle new data", bus.avalonst_source_data, 32'h6);
        check("same-cycle new valid", 32'(bus.avalonst_source_valid), 32'd1);
        check("same-cycle no overrun", 32'(bus.overrun), 32'd0);
        step();
        check("same-cycle drained", 32'(bus.avalonst_source_valid), 32'd0);

        // Overrun event beats a simultaneous clear_status.
        bus.fifo_almost_full = 1'b1;
        set_ch(3, 32'h7);
        bus.ch_valid = 4'b1000;
        step();
        set_ch(3, 32'h8);
        bus.clear_status = 1'b1;
        step();
        bus.ch_valid     = '0;
        bus.clear_status = 1'b0;
        check("overrun priority", 32'(bus.overrun), 32'h8);
        bus.clear_status = 1'b1;
        step();
        bus.clear_status = 1'b0;
        bus.fifo_almost_full = 1'b0;
        check("overrun cleared 2", 32'(bus.overrun), 32'd0);
        step();
        check("ch3 flush data", bus.avalonst_source_data, 32'h8);
        step(2);

        // Run frames until frame_count wraps (from 2, 254 more frames).
        bus.frame_mode = 1'b1;
        frames = 0;
        for (int f = 0; f < 300; f++) begin
            prev_fc = bus.frame_count;
            strobe_all(32'h100);
            for (int c = 0; c < 20 && bus.frame_count == prev_fc; c++) step();
            frames++;
            if (bus.frame_count == 8'd0) break;
        end
        check("wrap frames", 32'(frames), 32'd254);
        check("wrap frame_count", 32'(bus.frame_count), 32'd0);
        step(2);
        words.delete();
        strobe_all(32'h40);
        wait_words(5, 20, "wrap hdr count");
        check_frame("wrap", 32'hA5A5_0004, 32'h40);
        step(3);

        // Reset during DATA after two channels have been issued.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step();
        strobe_all(32'h30);
        step(4);
        check("midframe ch1 data", bus.avalonst_source_data, 32'h31);
        check("midframe ch1 valid", 32'(bus.avalonst_source_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort valid", 32'(bus.avalonst_source_valid), 32'd0);
        check("abort frame_count", 32'(bus.frame_count), 32'd0);
        words.delete();
        step(10);
        check("abort no words frame", 32'(words.size()), 32'd0);
        bus.frame_mode = 1'b0;
        step(10);
        check("abort no pending", 32'(words.size()), 32'd0);
        check("abort frame_count end", 32'(bus.frame_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/processor_amplitud_arbiter.md
PROCESSOR_AMPLITUD_ARBITER -- requirements
Module: processor_amplitud_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of amplitude requester channels (2..8).
REQ-002 Parameter DATA_W, default 32, width of each amplitude word and of the source port.
REQ-003 Parameter HDR_TAG, default 16'hA5A5, upper half of the frame header word.
REQ-004 Port clock  in  1  single clock; all logic on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port ch_data  in  NUM_CH*DATA_W  packed amplitude words; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port ch_valid  in  NUM_CH  one-cycle strobe per channel; qualifies the matching ch_data slice.
REQ-008 Port frame_mode  in  1  0 = stream mode, 1 = frame mode.
REQ-009 Port fifo_almost_full  in  1  high when the downstream output FIFO holds at least 15 of 16 words.
REQ-010 Port clear_status  in  1  one-cycle pulse; clears overrun flags.
REQ-011 Port avalonst_source_data  out  DATA_W  word to the FIFO data input.
REQ-012 Port avalonst_source_valid  out  1  FIFO write request; one word per high cycle.
REQ-013 Port overrun  out  NUM_CH  sticky per-channel overwrite flags.
REQ-014 Port frame_count  out  8  number of completed frames, modulo 256.

Function
REQ-015 Each channel SHALL have one holding register and one pending bit; ch_valid[i] SHALL load the register and set pending[i] on that edge.
REQ-016 If ch_valid[i] arrives while pending[i] is set and channel i is not being issued that cycle, the newest word SHALL overwrite the held word and overrun[i] SHALL set.
REQ-017 If ch_valid[i] arrives in the cycle channel i is issued, the issued word SHALL be the old one, the new word SHALL be held, pending[i] SHALL stay set, and overrun[i] SHALL NOT set.
REQ-018 Source outputs SHALL be registered; the minimum latency from the ch_valid sampling edge to avalonst_source_valid high SHALL be 2 edges.
REQ-019 No word SHALL be issued in a cycle where fifo_almost_full is high; held words SHALL persist until issued.
REQ-020 The FSM SHALL have states IDLE, HDR and DATA.
REQ-021 frame_mode SHALL be sampled only in IDLE and held until the FSM returns to IDLE.
REQ-022 Stream mode: the FSM SHALL remain in IDLE and issue at most one pending channel per cycle.
REQ-023 Stream-mode channel selection SHALL be round-robin, starting after the last-issued channel, with channel 0 first after reset.
REQ-024 Frame mode: IDLE SHALL go to HDR when all pending bits are set.
REQ-025 In HDR, the block SHALL issue the header {HDR_TAG, frame_count, NUM_CH[7:0]} and go to DATA.
REQ-026 In DATA, the block SHALL issue channels 0..NUM_CH-1 in index order, one per issuing cycle, using a channel counter.
REQ-027 After the last channel is issued, the FSM SHALL go to IDLE and frame_count SHALL increment, wrapping 255 to 0.
REQ-028 Stalls caused by fifo_almost_full in HDR or DATA SHALL hold the state and the channel counter.
REQ-029 Issuing a channel SHALL clear its pending bit unless REQ-017 applies.
REQ-030 clear_status SHALL clear overrun; a simultaneous overrun event SHALL take priority, leaving the bit set.

Reset
REQ-031 Reset SHALL force: state IDLE, all pending bits 0, overrun 0, frame_count 0, round-robin pointer 0, avalonst_source_valid 0, avalonst_source_data 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no further words issued; frame_count SHALL NOT increment.

Structure
REQ-033 State encoding, the default HDR_TAG and the header field layout SHALL live in a shared package, processor_amplitud_pkg.
REQ-034 Round-robin selection SHALL be a sub-module, processor_amplitud_rr_select (pending mask + last pointer in, one-hot grant + index out, combinational).

Verification
REQ-035 Stream mode, ch_valid = 4'b1111 with data 0x10..0x13 in one cycle, FIFO not full -> four consecutive valid words 0x10, 0x11, 0x12, 0x13; first word 2 edges after the strobe.
REQ-036 Frame mode, channels strobed on separate cycles with 0xA..0xD -> after the last strobe, 0xA5A5_0004, 0xA, 0xB, 0xC, 0xD; then frame_count = 1.
REQ-037 fifo_almost_full high for 5 cycles mid-frame -> no valid during the stall; frame resumes with the next channel, with no duplicate or lost word.
REQ-038 Channel 2 strobed twice (0x1, then 0x2) while the FIFO is held full -> overrun = 4'b0100 and 0x2 is issued; clear_status -> overrun = 0.
REQ-039 256 frames completed -> frame_count wraps to 0 and the header byte reads 0x00.
REQ-040 Reset during DATA after 2 channels are issued -> valid low the next cycle, state IDLE, pending 0, frame_count unchanged at 0.
